// File: rtl/muldiv_unit_pkg.sv
// Shared types for the execute-stage multiply/divide unit.
// Op encoding matches the RV32M funct3 field.
package common;

    typedef enum logic [2:0] {
        MD_MUL    = 3'd0,
        MD_MULH   = 3'd1,
        MD_MULHSU = 3'd2,
        MD_MULHU  = 3'd3,
        MD_DIV    = 3'd4,
        MD_DIVU   = 3'd5,
        MD_REM    = 3'd6,
        MD_REMU   = 3'd7
    } muldiv_op_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } muldiv_state_t;

endpackage

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit with valid/ready handshake.
// Shift-add multiply and restoring divide share one 2*XLEN accumulator.
import common::*;

module muldiv_unit #(
    parameter int XLEN           = 32,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  muldiv_op_t      control,
    input  logic [XLEN-1:0] left_operand,
    input  logic [XLEN-1:0] right_operand,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            zero_flag,
    output logic            div_by_zero,
    output logic            overflow
);

    localparam int N  = XLEN / BITS_PER_CYCLE;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    muldiv_state_t     state, state_next;
    muldiv_op_t        op_q;
    logic [XLEN-1:0]   mreg;
    logic [2*XLEN-1:0] acc;
    logic [CW-1:0]     cnt;
    logic              neg_q, rneg_q;
    logic [XLEN-1:0]   result_q;
    logic              dbz_q, ovf_q;

    logic              accept, a_signed, b_signed;
    logic              a_neg, b_neg, dz, ov, fast;
    logic [XLEN-1:0]   mag_a, mag_b, fast_res, fin_res;
    logic [2*XLEN-1:0] step, prod;
    logic [XLEN:0]     sum, rem_sh, diff;
    logic [XLEN-1:0]   quo, rem;

    assign in_ready    = (state == S_IDLE) && !flush;
    assign out_valid   = (state == S_DONE);
    assign result      = result_q;
    assign zero_flag   = (result_q == '0);
    assign div_by_zero = dbz_q;
    assign overflow    = ovf_q;
    assign accept      = in_valid && in_ready;

    always_comb begin
        a_signed = (control == MD_MULH) || (control == MD_MULHSU) ||
                   (control == MD_DIV)  || (control == MD_REM);
        b_signed = (control == MD_MULH) || (control == MD_DIV) ||
                   (control == MD_REM);
        a_neg    = a_signed && left_operand[XLEN-1];
        b_neg    = b_signed && right_operand[XLEN-1];
        mag_a    = a_neg ? -left_operand : left_operand;
        mag_b    = b_neg ? -right_operand : right_operand;
        dz       = control[2] && (right_operand == '0);
        ov       = (control == MD_DIV || control == MD_REM) &&
                   (left_operand == {1'b1, {(XLEN-1){1'b0}}}) &&
                   (&right_operand);
        fast     = dz || ov;
        fast_res = '0;
        if (dz)
            fast_res = control[1] ? left_operand : '1;
        else if (ov)
            fast_res = control[1] ? '0 : left_operand;
    end

    // One CALC iteration retires BITS_PER_CYCLE multiplier or quotient bits.
    always_comb begin
        step   = acc;
        sum    = '0;
        rem_sh = '0;
        diff   = '0;
        for (int i = 0; i < BITS_PER_CYCLE; i++) begin
            if (op_q[2]) begin
                rem_sh = step[2*XLEN-1:XLEN-1];
                diff   = rem_sh - {1'b0, mreg};
                if (!diff[XLEN])
                    step = {diff[XLEN-1:0], step[XLEN-2:0], 1'b1};
                else
                    step = {rem_sh[XLEN-1:0], step[XLEN-2:0], 1'b0};
            end else begin
                sum  = {1'b0, step[2*XLEN-1:XLEN]} +
                       (step[0] ? {1'b0, mreg} : '0);
                step = {sum, step[XLEN-1:1]};
            end
        end
    end

    always_comb begin
        prod    = neg_q ? -step : step;
        quo     = neg_q ? -step[XLEN-1:0] : step[XLEN-1:0];
        rem     = rneg_q ? -step[2*XLEN-1:XLEN] : step[2*XLEN-1:XLEN];
        fin_res = '0;
        unique case (op_q)
            MD_MUL:                      fin_res = prod[XLEN-1:0];
            MD_MULH, MD_MULHSU, MD_MULHU: fin_res = prod[2*XLEN-1:XLEN];
            MD_DIV, MD_DIVU:             fin_res = quo;
            MD_REM, MD_REMU:             fin_res = rem;
            default:                     fin_res = '0;
        endcase
    end

    always_comb begin
        state_next = state;
        unique case (state)
            S_IDLE: if (accept) state_next = fast ? S_DONE : S_CALC;
            S_CALC: if (cnt == '0) state_next = S_DONE;
            S_DONE: if (out_ready) state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
        if (flush)
            state_next = S_IDLE;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= S_IDLE;
        else
            state <= state_next;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_q     <= MD_MUL;
            mreg     <= '0;
            acc      <= '0;
            cnt      <= '0;
            neg_q    <= 1'b0;
            rneg_q   <= 1'b0;
            result_q <= '0;
            dbz_q    <= 1'b0;
            ovf_q    <= 1'b0;
        end else if (flush) begin
            dbz_q <= 1'b0;
            ovf_q <= 1'b0;
        end else if (accept) begin
            op_q   <= control;
            neg_q  <= a_neg ^ b_neg;
            rneg_q <= a_neg;
            cnt    <= CW'(N - 1);
            dbz_q  <= dz;
            ovf_q  <= ov;
            if (control[2]) begin
                acc  <= {{XLEN{1'b0}}, mag_a};
                mreg <= mag_b;
            end else begin
                acc  <= {{XLEN{1'b0}}, mag_b};
                mreg <= mag_a;
            end
            if (fast)
                result_q <= fast_res;
        end else if (state == S_CALC) begin
            acc <= step;
            if (cnt == '0)
                result_q <= fin_res;
            else
                cnt <= cnt - 1'b1;
        end
    end

endmodule
